// File: rtl/dsp_result_reader.sv
// Result buffer at the tail of the DSP48A1 pipeline: a valid-only push side feeding a first-word fall-through FIFO.
// The optional dropped-push counter is built only when DSP_RESULT_READER_DROPCNT_EN is defined.
module dsp_result_reader #(
    parameter int DATAWIDTH = 48,
    parameter int DEPTH     = 4,
    localparam int LVLW     = $clog2(DEPTH) + 1
) (
    input  logic                 CLK,
    input  logic                 rst_n,
    input  logic                 clkenable,
    input  logic                 in_valid,
    input  logic [DATAWIDTH-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] out_data,
    output logic [LVLW-1:0]      level,
    output logic                 full,
    output logic                 empty,
    output logic                 overflow,
    input  logic                 clr_ovf,
    output logic [15:0]          drop_cnt
);

    localparam int PTRW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ACTIVE,
        ST_FULL
    } state_t;

    state_t                r_state;
    state_t                w_stateNext;
    logic [LVLW-1:0]       r_level;
    logic [LVLW-1:0]       w_levelNext;
    logic [PTRW-1:0]       r_wrPtr;
    logic [PTRW-1:0]       r_rdPtr;
    logic [DATAWIDTH-1:0]  r_mem [DEPTH];
    logic                  r_overflow;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_drop;

    assign out_valid = (r_state != ST_EMPTY);
    assign empty     = (r_state == ST_EMPTY);
    assign full      = (r_state == ST_FULL);
    assign level     = r_level;
    assign overflow  = r_overflow;
    // Head slot is read straight from storage, so the output moves only on a clock edge.
    assign out_data  = r_mem[r_rdPtr];

    always_comb begin
        w_pop       = clkenable & out_valid & out_ready;
        w_push      = clkenable & in_valid & (~full | w_pop);
        w_drop      = clkenable & in_valid & full & ~w_pop;
        w_levelNext = r_level;
        w_stateNext = r_state;

        if (w_push && !w_pop) begin
            w_levelNext = r_level + LVLW'(1);
        end else if (w_pop && !w_push) begin
            w_levelNext = r_level - LVLW'(1);
        end

        case (r_state)
            ST_EMPTY: begin
                if (w_push) begin
                    w_stateNext = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (w_push && !w_pop && (r_level == LVLW'(DEPTH - 1))) begin
                    w_stateNext = ST_FULL;
                end else if (w_pop && !w_push && (r_level == LVLW'(1))) begin
                    w_stateNext = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_pop && !w_push) begin
                    w_stateNext = ST_ACTIVE;
                end
            end
            default: begin
                w_stateNext = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_level <= '0;
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            r_state <= w_stateNext;
            r_level <= w_levelNext;
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTRW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTRW'(1);
            end
        end
    end

    // Storage is cleared on reset so out_data reads zero until the first push lands.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wrPtr] <= in_data;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clkenable && clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

`ifdef DSP_RESULT_READER_DROPCNT_EN
    logic [15:0] r_dropCnt;

    // A drop coinciding with a clear restarts the count at one rather than losing it.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_dropCnt <= '0;
        end else if (clkenable) begin
            if (clr_ovf) begin
                r_dropCnt <= {15'd0, w_drop};
            end else if (w_drop && (r_dropCnt != 16'hFFFF)) begin
                r_dropCnt <= r_dropCnt + 16'd1;
            end
        end
    end

    assign drop_cnt = r_dropCnt;
`else
    assign drop_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_dsp_result_reader.sv
// Scoreboard bench for dsp_result_reader: directed scenarios plus random traffic against a queue-based model.
// Honours DSP_RESULT_READER_DROPCNT_EN for the drop counter expectations.
module tb_dsp_result_reader;

    localparam int DW    = 48;
    localparam int DEPTH = 4;
    localparam int LVLW  = $clog2(DEPTH) + 1;

    logic            CLK = 1'b0;
    logic            rst_n;
    logic            clkenable;
    logic            in_valid;
    logic [DW-1:0]   in_data;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [LVLW-1:0] level;
    logic            full;
    logic            empty;
    logic            overflow;
    logic            clr_ovf;
    logic [15:0]     drop_cnt;

    int nChecks = 0;
    int nFails  = 0;

    logic [DW-1:0] sbQ[$];
    logic [DW-1:0] mFifo[$];
    bit            mOvf;
    int            mDrop;

    dsp_result_reader #(.DATAWIDTH(DW), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .rst_n(rst_n), .clkenable(clkenable),
        .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level), .full(full), .empty(empty),
        .overflow(overflow), .clr_ovf(clr_ovf), .drop_cnt(drop_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compareState();
        checkOutput("level", 64'(level), 64'(mFifo.size()));
        checkOutput("empty", 64'(empty), 64'(mFifo.size() == 0));
        checkOutput("full", 64'(full), 64'(mFifo.size() == DEPTH));
        checkOutput("out_valid", 64'(out_valid), 64'(mFifo.size() != 0));
        if (mFifo.size() != 0) checkOutput("head_data", 64'(out_data), 64'(mFifo[0]));
        checkOutput("overflow", 64'(overflow), 64'(mOvf));
`ifdef DSP_RESULT_READER_DROPCNT_EN
        checkOutput("drop_cnt", 64'(drop_cnt), 64'(mDrop));
`else
        checkOutput("drop_cnt", 64'(drop_cnt), 64'(0));
`endif
    endtask

    // One clock of stimulus: drive inputs, advance the behavioural model, then compare after the edge.
    task automatic applyStimulus(input bit ce, input bit iv, input logic [DW-1:0] d,
                                 input bit rdy, input bit clr);
        bit pop, push, drop;
        clkenable = ce;
        in_valid  = iv;
        in_data   = d;
        out_ready = rdy;
        clr_ovf   = clr;
        pop  = ce && (mFifo.size() > 0) && rdy;
        push = ce && iv && ((mFifo.size() < DEPTH) || pop);
        drop = ce && iv && !push;
        if (pop) void'(mFifo.pop_front());
        if (push) begin
            mFifo.push_back(d);
            sbQ.push_back(d);
        end
        if (drop) mOvf = 1'b1;
        else if (ce && clr) mOvf = 1'b0;
        if (ce && clr) mDrop = drop ? 1 : 0;
        else if (drop && mDrop < 65535) mDrop++;
        @(posedge CLK);
        #1;
        compareState();
    endtask

    function automatic logic [DW-1:0] randWord();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    // Monitor: every accepted read must match the oldest word the scoreboard holds.
    always @(negedge CLK) begin
        if (rst_n && clkenable && out_valid && out_ready) begin
            if (sbQ.size() == 0) begin
                nChecks++;
                nFails++;
                $display("[TB] FAIL monitor_underflow: got 0x%0h, expected no valid output", out_data);
            end else begin
                checkOutput("monitor_data", 64'(out_data), 64'(sbQ.pop_front()));
            end
        end
    end

    initial begin
        rst_n = 1'b0; clkenable = 1'b0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b0; clr_ovf = 1'b0;
        mOvf = 1'b0; mDrop = 0;
        #12;
        checkOutput("rst_level", 64'(level), 64'(0));
        checkOutput("rst_empty", 64'(empty), 64'(1));
        checkOutput("rst_full", 64'(full), 64'(0));
        checkOutput("rst_valid", 64'(out_valid), 64'(0));
        checkOutput("rst_data", 64'(out_data), 64'(0));
        checkOutput("rst_ovf", 64'(overflow), 64'(0));
        checkOutput("rst_dropcnt", 64'(drop_cnt), 64'(0));
        #10 rst_n = 1'b1;
        @(posedge CLK); #1;

        // Latency and ordering with a reader that is always ready.
        applyStimulus(1, 1, 48'h1, 1, 0);
        checkOutput("lat_data1", 64'(out_data), 64'h1);
        applyStimulus(1, 1, 48'h2, 1, 0);
        checkOutput("lat_data2", 64'(out_data), 64'h2);
        applyStimulus(1, 1, 48'h3, 1, 0);
        checkOutput("lat_data3", 64'(out_data), 64'h3);
        checkOutput("lat_level", 64'(level), 64'(1));
        applyStimulus(1, 0, 48'h0, 1, 0);

        // Fill past capacity with the reader stalled.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 1, 48'hA + DW'(i), 0, 0);
            if (i == 3) checkOutput("full_after4", 64'(full), 64'(1));
        end
        checkOutput("drop_ovf", 64'(overflow), 64'(1));
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 48'h0, 1, 0);
        checkOutput("drained_empty", 64'(empty), 64'(1));

        // Simultaneous pop and push while full.
        for (int i = 0; i < 4; i++) applyStimulus(1, 1, 48'h20 + DW'(i), 0, 0);
        applyStimulus(1, 1, 48'h55, 1, 0);
        checkOutput("fullpp_level", 64'(level), 64'(4));
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 48'h0, 1, 0);
        checkOutput("fullpp_last", 64'(out_data), 64'h55);
        applyStimulus(1, 0, 48'h0, 1, 0);

        // Freeze with everything else active.
        applyStimulus(1, 1, 48'h77, 0, 0);
        applyStimulus(1, 1, 48'h78, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 48'h99, 1, 1);
        checkOutput("freeze_level", 64'(level), 64'(2));
        checkOutput("freeze_data", 64'(out_data), 64'h77);
        checkOutput("freeze_ovf", 64'(overflow), 64'(1));

        // Clear racing a drop, then a lone clear.
        applyStimulus(1, 1, 48'h79, 0, 0);
        applyStimulus(1, 1, 48'h7A, 0, 0);
        applyStimulus(1, 1, 48'h7B, 0, 1);
        checkOutput("race_ovf", 64'(overflow), 64'(1));
        applyStimulus(1, 0, 48'h0, 0, 1);
        checkOutput("clr_ovf", 64'(overflow), 64'(0));
        checkOutput("clr_dropcnt", 64'(drop_cnt), 64'(0));

        // Asynchronous reset in the middle of a burst at level 3.
        applyStimulus(1, 1, 48'h7C, 0, 0);
        applyStimulus(1, 0, 48'h0, 1, 0);
        checkOutput("pre_rst_level", 64'(level), 64'(3));
        in_valid = 1'b1; in_data = 48'hDEAD; out_ready = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        mFifo.delete(); sbQ.delete(); mOvf = 1'b0; mDrop = 0;
        checkOutput("midrst_level", 64'(level), 64'(0));
        checkOutput("midrst_valid", 64'(out_valid), 64'(0));
        checkOutput("midrst_data", 64'(out_data), 64'(0));
        checkOutput("midrst_ovf", 64'(overflow), 64'(0));
        in_valid = 1'b0;
        @(negedge CLK); #2 rst_n = 1'b1;
        @(posedge CLK); #1;
        compareState();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0, randWord(),
                          $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
        end

`ifdef DSP_RESULT_READER_DROPCNT_EN
        // Drive enough drops to saturate the counter.
        for (int i = 0; i < DEPTH; i++) applyStimulus(1, 1, randWord(), 0, 0);
        for (int i = 0; i < 65540; i++) applyStimulus(1, 1, randWord(), 0, 0);
        checkOutput("sat_dropcnt", 64'(drop_cnt), 64'hFFFF);
        applyStimulus(1, 0, 48'h0, 0, 1);
`endif

        for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1, 0, 48'h0, 1, 0);
        checkOutput("final_sb_empty", 64'(sbQ.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
